// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered, parametrised ALU with a valid/ready request handshake and a
//   persistent flag set (CF/ZF/SF/OF). Single-cycle ops complete on the edge
//   that accepts them; MUL (optional) runs an iterative shift-add over WIDTH
//   cycles while in_ready is held low.
//
//   Build option:
//     ALU_MUL_EN  defined   -> iterative multiplier, BUSY state and counter
//                 undefined -> opcode 1001 is a NOP, in_ready = !reset
//
// Parameters:
//   WIDTH      operand/result width (>= 2)
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request strobe, accepted when in_ready is high
//   in_ready   high when idle and out of reset
//   op         4-bit opcode
//   in1, in2   operands (sampled only on accept)
//   res        registered result, held until the next result-producing op
//   out_valid  one-cycle pulse when res/flags have just been updated
//   CF,ZF,SF,OF registered carry/zero/sign/overflow flags
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  output logic             CF,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_ADC   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_OR    = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_SHL   = 4'b0111,
    OP_SHR   = 4'b1000,
    OP_MUL   = 4'b1001,
    OP_SHOWR = 4'b1111
  } op_e;

  logic             accept;
  logic             carry_in;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;

  // Decoded single-cycle outcome.
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_cf;
  logic             nxt_of;
  logic             writes;      // op updates res and pulses out_valid
  logic             keep_flags;  // SHOWR: res only, flags untouched
  logic             start_mul;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   mplier;    // multiplier, shifted right each iteration
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE) && !reset;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
  assign in_ready = !reset;
`endif

  assign accept = in_valid && in_ready;

  // One shared (WIDTH+1)-bit adder serves ADD and ADC; the top bit is carry.
  assign carry_in = (op == OP_ADC) ? CF : 1'b0;
  assign add_sum  = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, carry_in};
  // Top bit of the widened difference is the unsigned borrow.
  assign sub_diff = {1'b0, in1} - {1'b0, in2};

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_res    = '0;
    nxt_cf     = 1'b0;
    nxt_of     = 1'b0;
    writes     = 1'b0;
    keep_flags = 1'b0;
    start_mul  = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        nxt_res = add_sum[WIDTH-1:0];
        nxt_cf  = add_sum[WIDTH];
        nxt_of  = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                  (add_sum[WIDTH-1] != in1[WIDTH-1]);
        writes  = 1'b1;
      end
      OP_SUB: begin
        nxt_res = sub_diff[WIDTH-1:0];
        nxt_cf  = sub_diff[WIDTH];
        nxt_of  = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                  (sub_diff[WIDTH-1] != in1[WIDTH-1]);
        writes  = 1'b1;
      end
      OP_AND: begin nxt_res = in1 & in2; writes = 1'b1; end
      OP_OR:  begin nxt_res = in1 | in2; writes = 1'b1; end
      OP_XOR: begin nxt_res = in1 ^ in2; writes = 1'b1; end
      OP_SHL: begin
        nxt_res = {in1[WIDTH-2:0], 1'b0};
        nxt_cf  = in1[WIDTH-1];
        nxt_of  = in1[WIDTH-1] ^ in1[WIDTH-2];
        writes  = 1'b1;
      end
      OP_SHR: begin
        nxt_res = {1'b0, in1[WIDTH-1:1]};
        nxt_cf  = in1[0];
        writes  = 1'b1;
      end
`ifdef ALU_MUL_EN
      OP_MUL: start_mul = 1'b1;
`endif
      OP_SHOWR: begin
        nxt_res    = in1;
        writes     = 1'b1;
        keep_flags = 1'b1;
      end
      default: ;  // NOP and reserved opcodes: nothing happens
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the multiplier working registers are reset along with the outputs;
  // they are few flops and this keeps an aborted MUL from leaving stale state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res       <= '0;
      CF        <= 1'b0;
      ZF        <= 1'b0;
      SF        <= 1'b0;
      OF        <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;

      // accept can only be true in IDLE, so this never collides with BUSY.
      if (accept && writes) begin
        res       <= nxt_res;
        out_valid <= 1'b1;
        if (!keep_flags) begin
          CF <= nxt_cf;
          OF <= nxt_of;
          ZF <= (nxt_res == '0);
          SF <= nxt_res[WIDTH-1];
        end
      end

`ifdef ALU_MUL_EN
      case (state)
        IDLE: begin
          if (accept && start_mul) begin
            state  <= BUSY;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, in1};
            mplier <= in2;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Last partial product is folded in on the completing edge.
          if (cnt == LAST) begin
            state     <= IDLE;
            res       <= acc_next[WIDTH-1:0];
            CF        <= |acc_next[2*WIDTH-1:WIDTH];
            OF        <= |acc_next[2*WIDTH-1:WIDTH];
            ZF        <= (acc_next[WIDTH-1:0] == '0);
            SF        <= acc_next[WIDTH-1];
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq (WIDTH=8). A behavioural model computes
//   each op with plain integer arithmetic; directed cases cover overflow,
//   carry chains, borrow, SHOWR/NOP preservation, MUL busy behaviour and
//   reset mid-MUL, followed by a randomized op sequence. Adapts to whether
//   ALU_MUL_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int     W    = 8;
  localparam longint M    = longint'(1) << W;
  localparam longint HALF = M / 2;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] in1, in2;
  logic [W-1:0] res;
  logic         out_valid;
  logic         CF, ZF, SF, OF;

  alu_seq #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .res      (res),
    .out_valid(out_valid),
    .CF       (CF),
    .ZF       (ZF),
    .SF       (SF),
    .OF       (OF)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference state
  longint m_res;
  bit     m_cf, m_zf, m_sf, m_of;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= HALF) ? v - M : v;
  endfunction

  function automatic bit ovf(input longint s);
    return (s > HALF - 1) || (s < -HALF);
  endfunction

  // Applies one op to the reference state; returns 1 if it produces a result.
  function automatic bit model(input logic [3:0] o, input longint a, input longint b);
    longint full;
    longint r;
    bit     cf, of;
    cf = 1'b0;
    of = 1'b0;
    case (o)
      4'h1: begin full = a + b; r = full % M; cf = full >= M; of = ovf(sgn(a) + sgn(b)); end
      4'h2: begin r = (a - b + M) % M; cf = a < b; of = ovf(sgn(a) - sgn(b)); end
      4'h3: begin
        full = a + b + longint'(m_cf);
        r    = full % M;
        cf   = full >= M;
        of   = ovf(sgn(a) + sgn(b) + longint'(m_cf));
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: begin r = (a * 2) % M; cf = a >= HALF; of = ovf(sgn(a) * 2); end
      4'h8: begin r = a / 2; cf = (a % 2) == 1; end
      4'h9: begin
        if (!MUL_EN) return 1'b0;
        full = a * b;
        r    = full % M;
        cf   = full >= M;
        of   = cf;
      end
      4'hF: begin m_res = a; return 1'b1; end
      default: return 1'b0;
    endcase
    m_res = r;
    m_cf  = cf;
    m_of  = of;
    m_zf  = (r == 0);
    m_sf  = (r >= HALF);
    return 1'b1;
  endfunction

  task automatic check_state(input string tag, input bit exp_valid);
    check({tag, ".res"},       res,       m_res[31:0]);
    check({tag, ".CF"},        CF,        m_cf);
    check({tag, ".ZF"},        ZF,        m_zf);
    check({tag, ".SF"},        SF,        m_sf);
    check({tag, ".OF"},        OF,        m_of);
    check({tag, ".out_valid"}, out_valid, exp_valid);
  endtask

  // Drive one request and check the completion (after WIDTH extra edges for MUL).
  task automatic apply_op(input string tag, input logic [3:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    bit produced;
    @(negedge clock);
    check({tag, ".ready_pre"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (o == 4'h9 && MUL_EN) begin
      for (int i = 0; i < W; i++) begin
        // Old values stay visible and the block refuses requests while busy.
        check({tag, ".busy_ready"}, in_ready, 1'b0);
        check_state({tag, ".busy"}, 1'b0);
        if (i == 2) begin
          in_valid = 1'b1;
          op       = 4'h1;
          in1      = W'($urandom);
          in2      = W'($urandom);
        end
        if (i == W - 1) in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    produced = model(o, longint'(a), longint'(b));
    check_state(tag, produced);
    check({tag, ".ready_post"}, in_ready, 1'b1);
  endtask

  // One edge with no request: out_valid must drop, state unchanged.
  task automatic idle_cycle(input string tag);
    @(posedge clock);
    #1;
    check_state(tag, 1'b0);
  endtask

  initial begin
    in_valid = 1'b0;
    op       = 4'h0;
    in1      = '0;
    in2      = '0;
    reset    = 1'b0;
    #2 reset = 1'b1;
    #1;
    m_res = 0; m_cf = 0; m_zf = 0; m_sf = 0; m_of = 0;
    check("reset.ready", in_ready, 1'b0);
    check_state("reset", 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset.ready_release", in_ready, 1'b1);

    // Signed overflow, then out_valid must last exactly one cycle.
    apply_op("add_ovf", 4'h1, 8'h7F, 8'h01);
    check("add_ovf.res_const", res, 8'h80);
    check("add_ovf.OF_const", OF, 1'b1);
    idle_cycle("add_ovf.drop");

    // Carry chain: ADC back-to-back sees the fresh CF.
    apply_op("add_carry", 4'h1, 8'hFF, 8'h01);
    check("add_carry.CF_const", CF, 1'b1);
    check("add_carry.ZF_const", ZF, 1'b1);
    apply_op("adc_chain", 4'h3, 8'h00, 8'h00);
    check("adc_chain.res_const", res, 8'h01);
    check("adc_chain.CF_const", CF, 1'b0);

    // Borrow, then SHOWR leaves flags alone, NOP/reserved produce nothing.
    apply_op("sub_borrow", 4'h2, 8'h05, 8'h07);
    check("sub_borrow.res_const", res, 8'hFE);
    apply_op("showr", 4'hF, 8'h3C, 8'h00);
    check("showr.res_const", res, 8'h3C);
    check("showr.CF_const", CF, 1'b1);
    check("showr.SF_const", SF, 1'b1);
    apply_op("nop", 4'h0, 8'h12, 8'h34);
    apply_op("rsv_c", 4'hC, 8'h56, 8'h78);
    apply_op("sub_ovf", 4'h2, 8'h80, 8'h01);
    check("sub_ovf.res_const", res, 8'h7F);
    check("sub_ovf.OF_const", OF, 1'b1);

    // Shift boundaries.
    apply_op("shl_ovf", 4'h7, 8'h40, 8'h00);
    apply_op("shr_zero", 4'h8, 8'h01, 8'h00);
    apply_op("logic_and", 4'h4, 8'hF0, 8'h0F);

    // Multiply with an ignored request during BUSY.
    apply_op("mul", 4'h9, 8'h10, 8'h11);
    if (MUL_EN) check("mul.res_const", res, 8'h10);
    idle_cycle("mul.drop");

    // Randomized sequence over all opcodes.
    for (int n = 0; n < 60; n++) begin
      apply_op("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
    end

    // Reset three cycles into a MUL aborts it.
    @(negedge clock);
    in_valid = 1'b1;
    op       = 4'h9;
    in1      = 8'hFF;
    in2      = 8'hFF;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    m_res = 0; m_cf = 0; m_zf = 0; m_sf = 0; m_of = 0;
    check("rst_mul.ready", in_ready, 1'b0);
    check_state("rst_mul", 1'b0);
    @(posedge clock);
    #1;
    check_state("rst_mul.hold", 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mul.ready_release", in_ready, 1'b1);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clock);
      #1;
      check("rst_mul.no_valid", out_valid, 1'b0);
    end

    apply_op("post_reset_add", 4'h1, 8'h22, 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit ALU. It has a valid/ready input handshake and a registered flag set (CF/ZF/SF/OF) that persists between operations. It adds SUB, ADC, logic, shifts and an optional iterative multiplier. It sits between the register file and the datapath writeback, and drives `res` plus the flags to the condition logic.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; must be ≥ 2.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept a request; high iff the FSM is in IDLE and `reset` is low.
- `op`  in  4: opcode.
- `in1`, `in2`  in  WIDTH: operands.
- `res`  out  WIDTH: registered result; held until the next result-producing op.
- `out_valid`  out  1: one-cycle pulse when `res` and the flags have just been updated.
- `CF`, `ZF`, `SF`, `OF`  out  1 each: registered flags.

## Operation
- Accept: a request is accepted on a rising edge with `in_valid && in_ready`. `op`, `in1` and `in2` are sampled only then.
- Opcodes. For every op, ZF = (res==0) and SF = res[WIDTH-1] unless stated otherwise.
  - 0000 NOP: accepted; nothing changes; no `out_valid`.
  - 0001 ADD: res = in1+in2. CF = carry out. OF = signed overflow (operands same sign, result sign differs).
  - 0010 SUB: res = in1−in2. CF = borrow (in1 < in2 unsigned). OF = signed overflow (operand signs differ, result sign ≠ in1 sign).
  - 0011 ADC: res = in1+in2+CF, using the current registered CF. CF and OF as for ADD.
  - 0100 AND, 0101 OR, 0110 XOR: bitwise. CF = OF = 0.
  - 0111 SHL: res = in1<<1. CF = in1[WIDTH-1]. OF = in1[WIDTH-1]^in1[WIDTH-2].
  - 1000 SHR: logical, res = in1>>1. CF = in1[0]. OF = 0.
  - 1001 MUL: unsigned, iterative shift-add over WIDTH cycles; res = low WIDTH bits of the product. CF = OF = (high half ≠ 0).
  - 1111 SHOWR: res = in1; all four flags unchanged; `out_valid` pulses.
  - 1010–1110: treated as NOP.
- FSM states:
  - IDLE → BUSY on accept of MUL.
  - BUSY counts WIDTH iterations, then returns to IDLE, writing `res`/flags and pulsing `out_valid` on the same edge.
  - All other ops complete from IDLE in one edge.
- Width rules: internal add/sub is WIDTH+1 bits; the MUL accumulator is 2·WIDTH bits; the iteration counter is $clog2(WIDTH)+1 bits.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `res`=0, CF=ZF=SF=OF=0, `out_valid`=0, `in_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Single-cycle ops accepted at edge k: `res`, flags and `out_valid`=1 are visible after edge k; `out_valid` drops after edge k+1 unless another op completes then.
- Back-to-back: single-cycle ops may be accepted every cycle. ADC accepted at edge k+1 sees the CF written at edge k.
- MUL accepted at edge k:
  - `in_ready`=0 after edges k … k+WIDTH−1.
  - result and `out_valid` appear after edge k+WIDTH.
  - `in_ready` returns high in the same cycle.
- `in_valid` while `in_ready`=0 is ignored: not queued, no side effects.
- `res` and flags are unchanged during BUSY; the old values stay visible until completion.
- Reset mid-MUL aborts the operation: no `out_valid` is produced and all outputs return to their reset values.

## Configuration
- `ALU_MUL_EN` defined: the MUL datapath, BUSY state and counter are compiled in; 1001 behaves as above.
- `ALU_MUL_EN` undefined: no multiplier logic; 1001 is a NOP (no state change, no `out_valid`); `in_ready` is constantly high outside reset.

## Test plan
(WIDTH=8, `ALU_MUL_EN` defined unless stated.)
- Signed overflow: ADD 0x7F+0x01 → after 1 edge: res=0x80, CF0 ZF1? no: ZF0, SF1, OF1, `out_valid` high exactly one cycle.
- Carry chain: ADD 0xFF+0x01 → res=0x00, CF1 ZF1 SF0 OF0. Next cycle ADC 0x00+0x00 → res=0x01, CF0 ZF0.
- Borrow: SUB 0x05−0x07 → res=0xFE, CF1 ZF0 SF1 OF0. Then SUB 0x80−0x01 → res=0x7F, OF1 CF0.
- Multiply: MUL 0x10×0x11 → `in_ready` low 8 cycles; an `in_valid` ADD during BUSY is ignored; after 8 edges res=0x10, CF1 OF1 ZF0 SF0, one `out_valid` pulse.
- Preservation: after the borrow case, SHOWR in1=0x3C → res=0x3C, flags still CF1 SF1. NOP and op 1100 → no `out_valid`, res and flags unchanged.
- Reset mid-MUL: assert `reset` 3 cycles into a MUL → outputs 0 immediately, `out_valid` never pulses, `in_ready`=1 the cycle after release. Rerun with `ALU_MUL_EN` undefined: MUL → no `out_valid`, `in_ready` stays 1.
